// File: rtl/sumador_serie.sv
// sumador_serie: sequential multi-nibble adder/subtractor.
// A single 4-bit add slice is reused across the NIBBLES slices of the operands.
// One nibble is handled per clock, least significant first, and the carry is
// kept in a register between cycles. Subtraction is A + ~B + 1: the operand is
// inverted when it is latched and the carry register is seeded with 1.
module sumador_serie #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Reject slice counts outside the supported range at elaboration time.
  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("sumador_serie: NIBBLES must be in 2..8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The one and only adder in the block: 4 bits + 4 bits + carry-in.
  function automatic logic [4:0] add_slice(input logic [3:0] a_nib,
                                           input logic [3:0] b_nib,
                                           input logic       cin);
    add_slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
  endfunction

  // Pick nibble i out of a WIDTH-bit word.
  function automatic logic [3:0] get_nibble(input logic [WIDTH-1:0] word,
                                            input logic [IDX_W-1:0] i);
    get_nibble = word[4*i +: 4];
  endfunction

  // Replace nibble i of a WIDTH-bit word, leaving the other bits untouched.
  function automatic logic [WIDTH-1:0] put_nibble(input logic [WIDTH-1:0] word,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [3:0]       nib);
    logic [WIDTH-1:0] r;
    r = word;
    r[4*i +: 4] = nib;
    put_nibble = r;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   opa_q,   opa_d;
  logic [WIDTH-1:0]   opb_q,   opb_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [4:0]         slice;

  // Next-state, operand capture and per-nibble accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    slice   = add_slice(get_nibble(opa_q, idx_q), get_nibble(opb_q, idx_q), carry_q);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          // Operands are frozen here so later input changes cannot disturb
          // the operation; sum/cout keep the previous result until RUN.
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        sum_d   = put_nibble(sum_q, idx_q, slice[3:0]);
        carry_d = slice[4];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice[4];
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        // start is deliberately not looked at here; it is not queued.
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Testbench for sumador_serie: directed cases plus random operations, each
// compared against a plain-arithmetic reference of the add/subtract result.
module tb_sumador_serie;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  sumador_serie #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub_i),
    .A     (a_i),
    .B     (b_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add gives a W+1 bit sum; subtract gives A-B modulo 2^W with
  // the carry meaning "no borrow", i.e. A >= B unsigned.
  function automatic logic [W:0] ref_result(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         s);
    logic [W-1:0] diff;
    if (!s) begin
      ref_result = {1'b0, a} + {1'b0, b};
    end else begin
      diff = a - b;
      ref_result = {(a >= b), diff};
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let one edge accept it; start is left asserted.
  task automatic launch(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s);
    a_i   = a;
    b_i   = b;
    sub_i = s;
    start = 1'b1;
    step();
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_accept_done"}, 32'(done), 32'd0);
  endtask

  // Called just after the accepting edge: follow the operation to its done
  // pulse, then confirm the pulse is single and the result is held.
  task automatic finish_op(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic s);
    int k;
    int busy_cnt;
    logic [W:0] exp;
    exp = ref_result(a, b, s);
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      k++;
    end
    check({tag, "_latency"},      32'(k),        32'(N + 1));
    check({tag, "_busy_cycles"},  32'(busy_cnt), 32'(N));
    check({tag, "_busy_at_done"}, 32'(busy),     32'd0);
    check({tag, "_sum"},          32'(sum),      32'(exp[W-1:0]));
    check({tag, "_cout"},         32'(cout),     32'(exp[W]));
    step();
    check({tag, "_done_single"},  32'(done),     32'd0);
    check({tag, "_busy_after"},   32'(busy),     32'd0);
    check({tag, "_sum_held"},     32'(sum),      32'(exp[W-1:0]));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    rst   = 1'b1;
    start = 1'b0;
    sub_i = 1'b0;
    a_i   = '0;
    b_i   = '0;

    // Reset state.
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    step();

    // Basic add.
    launch("add_1_1", 16'h0001, 16'h0001, 1'b0);
    start = 1'b0;
    finish_op("add_1_1", 16'h0001, 16'h0001, 1'b0);

    // Carry ripples through every nibble.
    launch("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
    start = 1'b0;
    finish_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0);

    // Subtraction without and with borrow.
    launch("sub_1234_0235", 16'h1234, 16'h0235, 1'b1);
    start = 1'b0;
    finish_op("sub_1234_0235", 16'h1234, 16'h0235, 1'b1);

    launch("sub_0_1", 16'h0000, 16'h0001, 1'b1);
    start = 1'b0;
    finish_op("sub_0_1", 16'h0000, 16'h0001, 1'b1);

    // start held high and operands changed mid-operation: the running
    // operation is unaffected and the next one starts only from IDLE.
    launch("hold_first", 16'h00FF, 16'h0001, 1'b0);
    a_i = 16'hAAAA;
    b_i = 16'hAAAA;
    finish_op("hold_first", 16'h00FF, 16'h0001, 1'b0);
    step();
    check("hold_second_accept", 32'(busy), 32'd1);
    start = 1'b0;
    finish_op("hold_second", 16'hAAAA, 16'hAAAA, 1'b0);

    // Reset in the second RUN cycle: outputs clear without waiting for an edge.
    launch("abort", 16'h8888, 16'h8888, 1'b0);
    start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done_rst", 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done_after", 32'(done), 32'd0);
      check("abort_idle_busy",     32'(busy), 32'd0);
    end
    launch("after_abort", 16'h8888, 16'h8888, 1'b0);
    start = 1'b0;
    finish_op("after_abort", 16'h8888, 16'h8888, 1'b0);

    // Random operations; inputs are scrambled right after acceptance.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rb = ra;
      launch("rand", ra, rb, rs);
      start = 1'b0;
      a_i   = W'($urandom);
      b_i   = W'($urandom);
      sub_i = ~rs;
      finish_op("rand", ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sumador_serie.md
# sumador_serie

Multi-nibble sequential adder/subtractor controller. It time-shares a single 4-bit add slice (4-bit A + 4-bit B + carry-in, 5-bit result) across the nibbles of a wide operand pair. It processes one nibble per clock, least significant first, and propagates the carry between cycles. It sits beside the combinational 4-bit sumador datapath as the block that sequences it for operands wider than 4 bits, exposing a start/busy/done handshake to the requester.

## Interface
- NIBBLES, 4: number of 4-bit slices; operand width WIDTH = 4*NIBBLES; legal range 2..8.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  final carry out of MSB nibble.

## Operation
- The one clock and the asynchronous active-high reset are decided; no other clock or reset exists.
- The FSM has three states: IDLE, RUN, DONE.
- On reset, state = IDLE and the nibble index idx = 0.
  - All internal registers (operand A, operand B, carry) = 0.
  - Outputs: busy=0, done=0, sum=0, cout=0.
- **IDLE:** if start=1 at an edge:
  - Latch A into opA.
  - Latch B into opB, or ~B if sub=1.
  - Set carry = sub, idx = 0, go to RUN.
  - sum and cout keep their previous values until overwritten.
- **RUN:** each edge computes {c, s} = opA[idx] + opB[idx] + carry as 5 bits.
  - Write s into sum[4*idx+3 : 4*idx].
  - Set carry = c.
  - If idx = NIBBLES-1: set cout = c, go to DONE.
  - Otherwise idx = idx+1.
- **DONE:** done=1 for exactly this cycle. The next edge always returns to IDLE.
- Arithmetic:
  - The result is modulo 2^WIDTH.
  - For add, cout=1 means unsigned overflow.
  - For sub, cout=1 means no borrow (A >= B unsigned) and cout=0 means borrow.
  - No signed overflow flag is produced.
- The block uses one 4-bit add slice; no WIDTH-bit adder is allowed.
- start while in RUN or DONE is ignored and not queued. A, B and sub may change freely after the start edge without affecting the operation in progress.
- sum and cout are held stable from the DONE cycle until the first RUN edge of the next operation. Partially updated sum bits during RUN are not valid.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is issued for the aborted operation.

## Timing
- Start accepted at edge E0. RUN occupies edges E1..E_NIBBLES. done is high for the cycle following edge E_NIBBLES.
- Latency: done rises NIBBLES+1 edges after the accepting edge (5 for the default).
- busy rises at E0 and falls at E_NIBBLES; busy and done are never high together.
- Earliest next accepted start: the edge after the DONE cycle (back-to-back throughput of one operation per NIBBLES+2 cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then 0x0001 + 0x0001 (sub=0) -> sum=0x0002, cout=0. done is a single-cycle pulse exactly 5 edges after start; busy is high for 4 cycles.
- 0xFFFF + 0x0001 -> sum=0x0000, cout=1. The carry ripples through all four RUN cycles.
- Subtraction:
  - 0x1234 - 0x0235 (sub=1) -> sum=0x0FFF, cout=1.
  - 0x0000 - 0x0001 -> sum=0xFFFF, cout=0.
- Start 0x00FF + 0x0001, then hold start=1 and change A/B to 0xAAAA during RUN.
  - Required: sum=0x0100 with a single done pulse.
  - A second operation begins only after IDLE is reached, and its result is 0xAAAA+0xAAAA = 0x5554 with cout=1.
- Assert rst at the 2nd RUN cycle of 0x8888 + 0x8888.
  - Outputs go to 0 immediately, asynchronously; no done pulse follows.
  - After release, 0x8888 + 0x8888 -> sum=0x1110, cout=1.
